// File: rtl/mux_nto1_led_scan.sv
// mux_nto1_led_scan
// An NCH:1 multiplexer, WIDTH bits per channel, that drives a bank of board LEDs.
// The channel is chosen in one of two ways:
//   - manual mode: from board switches, after they are synchronised and debounced
//   - auto-scan mode: from a timer that steps through the channels in turn
// The selected channel number and the LED data are both registered.
// While hold is high, the selection, the LED data and the scan timer are all frozen.

module mux_nto1_led_scan #(
    parameter int WIDTH       = 4,
    parameter int NCH         = 4,
    parameter int SELW        = 2,
    parameter int DEBOUNCE    = 4,
    parameter int SCAN_PERIOD = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   data_in,
    input  logic [SELW-1:0]        sel_sw,
    input  logic                   mode,
    input  logic                   hold,
    output logic [WIDTH-1:0]       led,
    output logic [SELW-1:0]        sel_led,
    output logic                   ch_change
);

    // Counter widths. Keep at least one bit when the terminal count is zero.
    localparam int DCW = (DEBOUNCE > 1)    ? $clog2(DEBOUNCE)    : 1;
    localparam int SCW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    localparam logic [DCW-1:0]  DEB_LAST  = DCW'(DEBOUNCE - 1);
    localparam logic [SCW-1:0]  SCAN_LAST = SCW'(SCAN_PERIOD - 1);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(NCH - 1);

    logic [SELW-1:0]  sw_s1_q, sw_s2_q;
    logic [SELW-1:0]  cand_q, cand_d;
    logic [SELW-1:0]  deb_sel_q, deb_sel_d;
    logic [DCW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             chg_q, chg_d;
    logic [WIDTH-1:0] ch_data;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sel_sw;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Debouncer, next state.
    // A candidate switch value is accepted only after it has stayed stable long enough.
    // An accepted value that is not a valid channel is dropped, so the previous selection is kept.
    always_comb begin
        cand_d    = cand_q;
        deb_sel_d = deb_sel_q;
        deb_cnt_d = deb_cnt_q;
        if (sw_s2_q != cand_q) begin
            cand_d    = sw_s2_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            if (32'(cand_q) < NCH) begin
                deb_sel_d = cand_q;
            end
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Debouncer state registers. These run in both modes and while hold is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q    <= '0;
            deb_sel_q <= '0;
            deb_cnt_q <= '0;
        end else begin
            cand_q    <= cand_d;
            deb_sel_q <= deb_sel_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Select and scan timer, next state.
    // Priority is: hold, then manual mode, then auto-scan.
    always_comb begin
        sel_d      = sel_q;
        scan_cnt_d = scan_cnt_q;
        if (hold) begin
            sel_d      = sel_q;
            scan_cnt_d = scan_cnt_q;
        end else if (!mode) begin
            sel_d      = deb_sel_q;
            scan_cnt_d = '0;
        end else if (scan_cnt_q == SCAN_LAST) begin
            sel_d      = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            scan_cnt_d = '0;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    // Channel mux, indexed by the registered select.
    // The loop compares against each valid channel, so a select value at or above NCH can never read past the end of data_in.
    always_comb begin
        ch_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_q == SELW'(c)) begin
                ch_data = data_in[c*WIDTH +: WIDTH];
            end
        end
    end

    // LED data and change-pulse, next state.
    // While hold is high, the LEDs keep their value and no pulse is raised.
    always_comb begin
        led_d = hold ? led_q : ch_data;
        chg_d = (sel_d != sel_q);
    end

    // Output registers: select, scan timer, LED data and change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            scan_cnt_q <= '0;
            led_q      <= '0;
            chg_q      <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            scan_cnt_q <= scan_cnt_d;
            led_q      <= led_d;
            chg_q      <= chg_d;
        end
    end

    assign led       = led_q;
    assign sel_led   = sel_q;
    assign ch_change = chg_q;

endmodule

// File: tb/tb_mux_nto1_led_scan.sv
// Directed testbench for mux_nto1_led_scan.
// The main instance uses the default parameters (NCH=4).
// A second instance with NCH=3 covers switch values that are not a valid channel.

module tb_mux_nto1_led_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [1:0]  sel_sw;
    logic        mode;
    logic        hold;
    logic [3:0]  led;
    logic [1:0]  sel_led;
    logic        ch_change;

    logic [11:0] data_in3;
    logic [1:0]  sel_sw3;
    logic [3:0]  led3;
    logic [1:0]  sel_led3;
    logic        ch_change3;

    int n_vec = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    mux_nto1_led_scan u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sel_sw(sel_sw),
        .mode(mode), .hold(hold), .led(led), .sel_led(sel_led),
        .ch_change(ch_change)
    );

    mux_nto1_led_scan #(.WIDTH(4), .NCH(3), .SELW(2), .DEBOUNCE(4), .SCAN_PERIOD(8)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(data_in3), .sel_sw(sel_sw3),
        .mode(1'b0), .hold(1'b0), .led(led3), .sel_led(sel_led3),
        .ch_change(ch_change3)
    );

    // Compare one observed value against its expected value and count the result.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and wait until just after the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = 16'h3A5C;    // ch3=3 ch2=A ch1=5 ch0=C
        sel_sw   = 2'd0;
        mode     = 1'b0;
        hold     = 1'b0;
        data_in3 = 12'h9E7;     // ch2=9 ch1=E ch0=7
        sel_sw3  = 2'd0;

        // 1: reset state, then the first LED value after release
        repeat (3) tick();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_sel", 32'(sel_led), 32'h0);
        chk("rst_chg", 32'(ch_change), 32'h0);
        rst = 1'b0;
        tick();
        chk("rel_led_ch0", 32'(led), 32'hC);
        chk("rel_sel", 32'(sel_led), 32'h0);
        repeat (8) tick();

        // 2: manual select of channel 2
        // sel_led should change at edge DEBOUNCE+4 = 8, counting the first edge after the switch change as 1.
        sel_sw = 2'd2;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ch_change) pulses++;
            if (i == 7) chk("man_sel_e7", 32'(sel_led), 32'h0);
            if (i == 8) begin
                chk("man_sel_e8", 32'(sel_led), 32'h2);
                chk("man_chg_e8", 32'(ch_change), 32'h1);
                chk("man_led_e8", 32'(led), 32'hC);
            end
            if (i == 9) chk("man_led_e9", 32'(led), 32'hA);
        end
        chk("man_pulses", 32'(pulses), 32'h1);

        // Return to channel 0 before the bounce test.
        sel_sw = 2'd0;
        repeat (12) tick();
        chk("back_sel0", 32'(sel_led), 32'h0);

        // 3: bounce, toggling the switch every 2 cycles (shorter than DEBOUNCE)
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            sel_sw = ((i / 2) % 2 == 0) ? 2'd1 : 2'd0;
            tick();
            if (ch_change) pulses++;
        end
        sel_sw = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ch_change) pulses++;
        end
        chk("bnc_sel", 32'(sel_led), 32'h0);
        chk("bnc_pulses", 32'(pulses), 32'h0);

        // 4: auto-scan from channel 0, stepping every 8 edges and wrapping after channel 3
        mode = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (ch_change) pulses++;
            if (i == 7) chk("scan_sel_e7", 32'(sel_led), 32'h0);
            if (i % 8 == 0) begin
                chk($sformatf("scan_sel_e%0d", i), 32'(sel_led), 32'((i / 8) % 4));
                chk($sformatf("scan_chg_e%0d", i), 32'(ch_change), 32'h1);
            end
            if (i == 9) chk("scan_led_ch1", 32'(led), 32'h5);
        end
        chk("scan_pulses", 32'(pulses), 32'h4);

        // 5: hold in the middle of a scan period (scan_cnt is 3 when hold rises)
        repeat (3) tick();
        hold = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            data_in = (i % 2 == 0) ? 16'h9876 : 16'h1234;
            tick();
            if (ch_change) pulses++;
        end
        chk("hold_led", 32'(led), 32'hC);
        chk("hold_sel", 32'(sel_led), 32'h0);
        chk("hold_pulses", 32'(pulses), 32'h0);
        data_in = 16'h3A5C;
        hold = 1'b0;
        // After release, 4 edges take scan_cnt from 3 to 7; the 5th edge advances the channel.
        repeat (4) tick();
        chk("resume_sel_e4", 32'(sel_led), 32'h0);
        tick();
        chk("resume_sel_e5", 32'(sel_led), 32'h1);
        chk("resume_chg_e5", 32'(ch_change), 32'h1);

        // 6a: asynchronous reset in the middle of a scan
        // Outputs must clear before the next clock edge.
        tick();
        chk("pre_rst_led", 32'(led), 32'h5);
        rst = 1'b1;
        #2;
        chk("arst_led", 32'(led), 32'h0);
        chk("arst_sel", 32'(sel_led), 32'h0);
        chk("arst_chg", 32'(ch_change), 32'h0);
        mode = 1'b0;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_led", 32'(led), 32'hC);

        // 6b: NCH=3 instance; switch value 3 is not a valid channel and is ignored
        sel_sw3 = 2'd1;
        repeat (10) tick();
        chk("oor_sel1", 32'(sel_led3), 32'h1);
        chk("oor_led1", 32'(led3), 32'hE);
        sel_sw3 = 2'd3;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ch_change3) pulses++;
        end
        chk("oor_sel_kept", 32'(sel_led3), 32'h1);
        chk("oor_pulses", 32'(pulses), 32'h0);
        sel_sw3 = 2'd2;
        repeat (10) tick();
        chk("oor_sel2", 32'(sel_led3), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
